// File: rtl/rle_pkg.sv
// Shared types and constants for the zero-run merge path: segment/merged descriptors,
// controller state encoding and the input sanity check.
package rle_pkg;

  localparam int unsigned SEG_N     = 16;
  localparam int unsigned COEF_W    = 14;
  localparam int unsigned SEG_ARR_W = SEG_N * COEF_W;   // 224
  localparam int unsigned MRG_ARR_W = 2 * SEG_ARR_W;    // 448
  // Each entry is {run[13:8], level[7:0]}; the run field carries the zero run before the level.
  localparam int unsigned RUN_W     = 6;

  typedef enum logic [1:0] {
    S_LEFT  = 2'd0,
    S_RIGHT = 2'd1,
    S_EMIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]           lz;
    logic [3:0]           tz;
    logic                 nz;
    logic [SEG_ARR_W-1:0] arr;
    logic [4:0]           size;
  } seg_t;

  typedef struct packed {
    logic [4:0]           lz;
    logic [4:0]           tz;
    logic                 nz;
    logic [MRG_ARR_W-1:0] arr;
    logic [5:0]           size;
  } mrg_t;

  localparam seg_t ZERO_SEG = '0;

  function automatic logic seg_malformed(input logic nz, input logic [4:0] size);
    return (size > 5'(SEG_N)) || (!nz && (size != 5'd0));
  endfunction

endpackage

// File: rtl/module_32bit.sv
// Combinational merge of two 16-coef RLE segments into one 32-coef descriptor.
// The left segment is always a real 16-coef segment; the right may be an implicit pad.
module module_32bit
  import rle_pkg::*;
(
  input  seg_t left_i,
  input  seg_t right_i,
  input  logic right_real_i,
  output mrg_t merged_o
);

  logic [SEG_ARR_W-1:0] l_arr;
  logic [SEG_ARR_W-1:0] r_arr;
  logic [MRG_ARR_W-1:0] r_shift;
  logic [8:0]           shamt;
  logic [RUN_W-1:0]     l_zeros;
  logic [RUN_W-1:0]     mid_run;

  always_comb begin
    l_arr = left_i.arr;
    r_arr = right_i.arr;
    for (int unsigned i = 0; i < SEG_N; i++) begin
      if (5'(i) >= left_i.size) l_arr[i*COEF_W +: COEF_W] = '0;
      if (5'(i) >= right_i.size) r_arr[i*COEF_W +: COEF_W] = '0;
    end

    // An all-zero left contributes its full 16 coefs to the run ahead of the right's first level.
    l_zeros = left_i.nz ? {2'b00, left_i.tz} : RUN_W'(SEG_N);
    mid_run = l_zeros + {2'b00, right_i.lz};
    if (right_i.nz && (right_i.size != 5'd0)) r_arr[COEF_W-1 -: RUN_W] = mid_run;

    shamt   = 9'(left_i.size) * 9'(COEF_W);
    r_shift = {{SEG_ARR_W{1'b0}}, r_arr} << shamt;

    merged_o      = '0;
    merged_o.arr  = {{SEG_ARR_W{1'b0}}, l_arr} | r_shift;
    merged_o.size = {1'b0, left_i.size} + {1'b0, right_i.size};
    merged_o.nz   = left_i.nz | right_i.nz;

    unique case ({left_i.nz, right_i.nz})
      2'b11: begin
        merged_o.lz = {1'b0, left_i.lz};
        merged_o.tz = {1'b0, right_i.tz};
      end
      2'b10: begin
        merged_o.lz = {1'b0, left_i.lz};
        merged_o.tz = right_real_i ? ({1'b0, left_i.tz} + 5'(SEG_N)) : {1'b0, left_i.tz};
      end
      2'b01: begin
        merged_o.lz = 5'(SEG_N) + {1'b0, right_i.lz};
        merged_o.tz = {1'b0, right_i.tz};
      end
      default: begin
        // 32 zeros cannot be expressed in 5 bits, so a fully-zero pair reports 0/0.
        merged_o.lz = right_real_i ? 5'd0 : 5'(SEG_N);
        merged_o.tz = right_real_i ? 5'd0 : 5'(SEG_N);
      end
    endcase
  end

endmodule

// File: rtl/rle_merge_ctrl.sv
// Pairs consecutive 16-coef segment descriptors, merges them through module_32bit and
// presents the registered 32-coef result on a valid/ready output stream.
module rle_merge_ctrl
  import rle_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_lz,
  input  logic [3:0]           in_tz,
  input  logic                 in_nz,
  input  logic [SEG_ARR_W-1:0] in_array,
  input  logic [4:0]           in_size,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_lz,
  output logic [4:0]           out_tz,
  output logic                 out_nz,
  output logic [MRG_ARR_W-1:0] out_array,
  output logic [5:0]           out_size,
  output logic                 out_last,
  output logic [CNT_W-1:0]     out_idx,
  output logic                 err
);

  state_e           state_q, state_d;
  seg_t             left_q, left_d;
  mrg_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  seg_t in_seg;
  logic in_bad;
  seg_t mrg_left;
  seg_t mrg_right;
  logic mrg_right_real;
  mrg_t merged;
  logic load_left;

  always_comb begin
    in_bad = seg_malformed(in_nz, in_size);
    in_seg = ZERO_SEG;
    if (!in_bad) begin
      in_seg.lz   = in_lz;
      in_seg.tz   = in_tz;
      in_seg.nz   = in_nz;
      in_seg.arr  = in_array;
      in_seg.size = in_size;
    end
  end

  // Outside S_RIGHT the merger only ever sees an odd-tail left paired with the pad segment.
  always_comb begin
    mrg_right_real = (state_q == S_RIGHT);
    mrg_left       = mrg_right_real ? left_q : in_seg;
    mrg_right      = mrg_right_real ? in_seg : ZERO_SEG;
  end

  module_32bit u_merge (
    .left_i       (mrg_left),
    .right_i      (mrg_right),
    .right_real_i (mrg_right_real),
    .merged_o     (merged)
  );

  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    idx_d       = idx_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    load_left   = 1'b0;

    unique case (state_q)
      S_LEFT: begin
        in_ready  = 1'b1;
        load_left = in_valid;
      end
      S_RIGHT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          out_d       = merged;
          out_last_d  = in_last;
          out_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          idx_d       = out_last_q ? '0 : idx_q + CNT_W'(1);
          state_d     = S_LEFT;
          load_left   = in_valid;
        end
      end
      default: state_d = S_LEFT;
    endcase

    if (load_left) begin
      left_d = in_seg;
      if (in_last) begin
        out_d       = merged;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end else begin
        state_d = S_RIGHT;
      end
    end

    if (in_valid && in_ready && in_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LEFT;
      left_q      <= ZERO_SEG;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_lz    = out_q.lz;
  assign out_tz    = out_q.tz;
  assign out_nz    = out_q.nz;
  assign out_array = out_q.arr;
  assign out_size  = out_q.size;
  assign out_last  = out_last_q;
  assign out_idx   = idx_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rle_merge_ctrl.sv
// Directed bench for rle_merge_ctrl with a queue scoreboard fed by a coefficient-level model.
module tb_rle_merge_ctrl;

  typedef struct packed {
    logic [3:0]   lz;
    logic [3:0]   tz;
    logic         nz;
    logic [4:0]   size;
    logic [223:0] arr;
  } tseg_t;

  typedef struct packed {
    logic [4:0]   lz;
    logic [4:0]   tz;
    logic         nz;
    logic [5:0]   size;
    logic [447:0] arr;
    logic         last;
    logic [7:0]   idx;
  } texp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_lz;
  logic [3:0]   in_tz;
  logic         in_nz;
  logic [223:0] in_array;
  logic [4:0]   in_size;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_lz;
  logic [4:0]   out_tz;
  logic         out_nz;
  logic [447:0] out_array;
  logic [5:0]   out_size;
  logic         out_last;
  logic [7:0]   out_idx;
  logic         err;

  rle_merge_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lz     (in_lz),
    .in_tz     (in_tz),
    .in_nz     (in_nz),
    .in_array  (in_array),
    .in_size   (in_size),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lz    (out_lz),
    .out_tz    (out_tz),
    .out_nz    (out_nz),
    .out_array (out_array),
    .out_size  (out_size),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .err       (err)
  );

  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_pass  = 0;
  texp_t sb[$];
  bit    have_left = 1'b0;
  tseg_t lseg;
  int    push_idx = 0;
  bit    exp_err = 1'b0;

  task automatic check(input string tag, input logic [447:0] got, input logic [447:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic tseg_t mk(input int lz, input int tz, input bit nz, input int size,
                               input int base);
    tseg_t s;
    s      = '0;
    s.lz   = 4'(lz);
    s.tz   = 4'(tz);
    s.nz   = nz;
    s.size = 5'(size);
    for (int i = 0; i < size && i < 16; i++) s.arr[i*14 +: 14] = {6'(i == 0 ? lz : i), 8'(base + i)};
    return s;
  endfunction

  // Reference merge: lay out the used entries one by one, then derive the zero counts.
  function automatic texp_t model(input tseg_t l, input tseg_t r, input bit r_real);
    texp_t        e;
    int           k;
    int           span;
    logic [13:0]  ent;
    e = '0;
    k = 0;
    for (int i = 0; i < int'(l.size); i++) begin
      e.arr[k*14 +: 14] = l.arr[i*14 +: 14];
      k++;
    end
    for (int i = 0; i < int'(r.size); i++) begin
      ent = r.arr[i*14 +: 14];
      if (i == 0 && r.nz) ent[13:8] = 6'((l.nz ? int'(l.tz) : 16) + int'(r.lz));
      e.arr[k*14 +: 14] = ent;
      k++;
    end
    e.size = 6'(k);
    e.nz   = l.nz | r.nz;
    span   = r_real ? 32 : 16;
    if (l.nz) e.lz = 5'(l.lz);
    else if (r.nz) e.lz = 5'(16 + int'(r.lz));
    else e.lz = (span > 31) ? 5'd0 : 5'(span);
    if (r.nz) e.tz = 5'(r.tz);
    else if (l.nz) e.tz = 5'(int'(l.tz) + (r_real ? 16 : 0));
    else e.tz = (span > 31) ? 5'd0 : 5'(span);
    return e;
  endfunction

  task automatic push(input texp_t e, input bit last);
    e.last   = last;
    e.idx    = 8'(push_idx);
    push_idx = last ? 0 : (push_idx + 1) % 256;
    sb.push_back(e);
  endtask

  // Entered just after a rising edge; returns just after the edge that accepted the segment.
  task automatic send(input tseg_t s, input bit last);
    tseg_t m;
    bit    ok;
    in_valid = 1'b1;
    in_lz    = s.lz;
    in_tz    = s.tz;
    in_nz    = s.nz;
    in_size  = s.size;
    in_array = s.arr;
    in_last  = last;
    ok       = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    check("in_accept", 448'(ok), 448'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m = s;
    if (s.size > 5'd16 || (!s.nz && s.size != 5'd0)) begin
      m       = '0;
      exp_err = 1'b1;
    end
    if (!have_left) begin
      if (last) push(model(m, '0, 1'b0), 1'b1);
      else begin
        lseg      = m;
        have_left = 1'b1;
      end
    end else begin
      push(model(lseg, m, 1'b1), last);
      have_left = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    texp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 448'(out_valid), 448'(0));
      end else begin
        e = sb.pop_front();
        check("out_lz", 448'(out_lz), 448'(e.lz));
        check("out_tz", 448'(out_tz), 448'(e.tz));
        check("out_nz", 448'(out_nz), 448'(e.nz));
        check("out_size", 448'(out_size), 448'(e.size));
        check("out_array", out_array, e.arr);
        check("out_last", 448'(out_last), 448'(e.last));
        check("out_idx", 448'(out_idx), 448'(e.idx));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_lz     = '0;
    in_tz     = '0;
    in_nz     = 1'b0;
    in_array  = '0;
    in_size   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 448'(out_valid), 448'(0));
    check("rst_err", 448'(err), 448'(0));
    check("rst_in_ready", 448'(in_ready), 448'(1));
    check("rst_out_idx", 448'(out_idx), 448'(0));
    check("rst_out_last", 448'(out_last), 448'(0));
    check("rst_out_array", out_array, 448'(0));
    @(posedge clk);
    #1;

    // Reset while a left segment is held: it must be forgotten.
    send(mk(3, 1, 1'b1, 5, 8'h70), 1'b0);
    rst       = 1'b1;
    have_left = 1'b0;
    push_idx  = 0;
    exp_err   = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 448'(out_valid), 448'(0));
    check("midrst_in_ready", 448'(in_ready), 448'(1));
    check("midrst_err", 448'(err), 448'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic pair.
    send(mk(2, 0, 1'b1, 3, 8'h10), 1'b0);
    send(mk(0, 5, 1'b1, 4, 8'h20), 1'b1);
    @(negedge clk);
    check("pair_lz", 448'(out_lz), 448'(2));
    check("pair_tz", 448'(out_tz), 448'(5));
    check("pair_size", 448'(out_size), 448'(7));
    check("pair_idx", 448'(out_idx), 448'(0));
    check("pair_last", 448'(out_last), 448'(1));
    @(posedge clk);
    #1;

    // Mid run injected into the right's first entry.
    send(mk(1, 3, 1'b1, 1, 8'h30), 1'b0);
    send(mk(4, 0, 1'b1, 2, 8'h40), 1'b1);
    @(negedge clk);
    check("midrun_entry1_run", 448'(out_array[27:22]), 448'(7));
    check("midrun_size", 448'(out_size), 448'(3));
    @(posedge clk);
    #1;

    // Odd tail: third segment all-zero with last.
    send(mk(0, 2, 1'b1, 6, 8'h50), 1'b0);
    send(mk(1, 0, 1'b1, 9, 8'h60), 1'b0);
    send(mk(0, 0, 1'b0, 0, 0), 1'b1);
    @(negedge clk);
    check("tail_lz", 448'(out_lz), 448'(16));
    check("tail_tz", 448'(out_tz), 448'(16));
    check("tail_nz", 448'(out_nz), 448'(0));
    check("tail_last", 448'(out_last), 448'(1));
    check("tail_idx", 448'(out_idx), 448'(1));
    @(posedge clk);
    #1;

    // Backpressure: result held, input stalled, then output and next left in one cycle.
    out_ready = 1'b0;
    send(mk(5, 1, 1'b1, 4, 8'h80), 1'b0);
    send(mk(2, 3, 1'b1, 16, 8'h90), 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 448'(out_valid), 448'(1));
      check("bp_in_ready", 448'(in_ready), 448'(0));
      check("bp_out_lz", 448'(out_lz), 448'(sb[0].lz));
      check("bp_out_array", out_array, sb[0].arr);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(mk(0, 4, 1'b1, 2, 8'hA0), 1'b0);
    @(negedge clk);
    check("bp_after_valid", 448'(out_valid), 448'(0));
    @(posedge clk);
    #1;
    send(mk(3, 2, 1'b1, 16, 8'hB0), 1'b1);

    // Malformed inputs: oversize left, then nz=0 with entries on the right.
    send(mk(1, 1, 1'b1, 17, 8'hC0), 1'b0);
    send(mk(2, 3, 1'b1, 2, 8'hD0), 1'b1);
    @(negedge clk);
    check("bad_err", 448'(err), 448'(exp_err));
    check("bad_lz", 448'(out_lz), 448'(18));
    @(posedge clk);
    #1;
    send(mk(0, 2, 1'b1, 2, 8'hE0), 1'b0);
    send(mk(0, 0, 1'b0, 2, 8'hF0), 1'b1);
    @(negedge clk);
    check("badr_tz", 448'(out_tz), 448'(18));
    @(posedge clk);
    #1;
    send(mk(4, 4, 1'b1, 8, 8'h11), 1'b0);
    send(mk(6, 7, 1'b1, 5, 8'h22), 1'b1);
    @(negedge clk);
    check("err_sticky", 448'(err), 448'(1));

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    check("sb_drained", 448'(sb.size()), 448'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
